// File: rtl/wb_bus_watchdog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_watchdog_pkg
// Description : Shared definitions for the Wishbone bus watchdog: FSM state
//               encoding, CSR offsets, STATUS bit positions, the user-project
//               address page and the default error read data.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ERR_ACK = 2'd2,
        ST_CSR_ACK = 2'd3
    } wd_state_e;

    localparam logic [7:0]  CSR_OFF_STATUS   = 8'h00;
    localparam logic [7:0]  CSR_OFF_TO_COUNT = 8'h04;
    localparam logic [7:0]  CSR_OFF_LAST_ADR = 8'h08;
    localparam logic [7:0]  CSR_OFF_LIMIT    = 8'h0C;

    localparam int          STATUS_TO_BIT    = 0;
    localparam int          STATUS_BUSY_BIT  = 1;

    localparam logic [7:0]  USER_PAGE        = 8'h30;
    localparam logic [31:0] ERR_DATA_DEF     = 32'hDEAD_BEEF;
    localparam logic [15:0] LIMIT_MIN        = 16'd2;

    // A limit below two cycles would leave no room for the WAIT state.
    function automatic logic [15:0] clamp_limit(input logic [15:0] value);
        return (value < LIMIT_MIN) ? LIMIT_MIN : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog_csr.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog_csr
// Description : Register file of the bus watchdog. Holds the sticky timeout
//               flag, saturating timeout counter, last faulting address and
//               the timeout limit, plus the registered read mux.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               wr_en, rd_en     - CSR write commit / read capture strobes
//               offset, sel, wdata - CSR offset, byte selects, write data
//               busy             - watchdog FSM is not idle
//               err_event, err_adr - timeout termination and its address
//               rdata            - registered read data for the CSR ack
//               limit, to_flag   - active timeout limit, sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog_csr
    import wb_bus_watchdog_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_DEF = 16'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  offset,
    input  logic [1:0]  sel,
    input  logic [15:0] wdata,
    input  logic        busy,
    input  logic        err_event,
    input  logic [31:0] err_adr,
    output logic [31:0] rdata,
    output logic [15:0] limit,
    output logic        to_flag
);

    logic [15:0] to_count;
    logic [31:0] last_adr;
    logic [31:0] rd_mux;
    logic [15:0] limit_wr;

    always_comb begin
        rd_mux = '0;
        case (offset)
            CSR_OFF_STATUS: begin
                rd_mux[STATUS_TO_BIT]   = to_flag;
                rd_mux[STATUS_BUSY_BIT] = busy;
            end
            CSR_OFF_TO_COUNT: rd_mux[15:0] = to_count;
            CSR_OFF_LAST_ADR: rd_mux       = last_adr;
            CSR_OFF_LIMIT:    rd_mux[15:0] = limit;
            default:          rd_mux       = '0;
        endcase
    end

    // Byte-lane merge of a LIMIT write before clamping.
    assign limit_wr = {sel[1] ? wdata[15:8] : limit[15:8],
                       sel[0] ? wdata[7:0]  : limit[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_flag  <= 1'b0;
            to_count <= '0;
            last_adr <= '0;
            limit    <= TIMEOUT_DEF;
            rdata    <= '0;
        end else begin
            if (rd_en) begin
                rdata <= rd_mux;
            end
            // A timeout and a CSR write never share a cycle (distinct FSM states).
            if (err_event) begin
                to_flag  <= 1'b1;
                last_adr <= err_adr;
                if (to_count != 16'hFFFF) begin
                    to_count <= to_count + 16'd1;
                end
            end else if (wr_en) begin
                case (offset)
                    CSR_OFF_STATUS: begin
                        if (sel[0] && wdata[STATUS_TO_BIT]) begin
                            to_flag <= 1'b0;
                        end
                    end
                    CSR_OFF_TO_COUNT: to_count <= '0;
                    CSR_OFF_LIMIT:    limit    <= clamp_limit(limit_wr);
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_watchdog
// Description : Wishbone watchdog placed in front of the user-project address
//               decoder. Forwards transactions unchanged, counts wait cycles
//               and terminates a cycle with ERR_DATA when the slave does not
//               ack within LIMIT cycles. Serves a local CSR page.
// Ports       : wb_clk_i, wb_rst_i - clock, asynchronous active-high reset
//               wbs_*_i / wbs_*_o  - slave port facing the Caravel master
//               dec_*_o / dec_*_i  - master port facing the address decoder
//               timeout_irq_o      - level interrupt, mirrors STATUS.TO
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_watchdog
    import wb_bus_watchdog_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_DEF = 16'd255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF,
    parameter logic [3:0]  CSR_PAGE    = 4'hF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dec_cyc_o,
    output logic        dec_stb_o,
    output logic        dec_we_o,
    output logic [3:0]  dec_sel_o,
    output logic [31:0] dec_dat_o,
    output logic [31:0] dec_adr_o,
    input  logic        dec_ack_i,
    input  logic [31:0] dec_dat_i,
    output logic        timeout_irq_o
);

    wd_state_e   state;
    wd_state_e   state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        req;
    logic        csr_hit;
    logic        fwd_block;
    logic        ack;
    logic [31:0] dat;
    logic        err_event;
    logic [31:0] csr_rdata;
    logic [15:0] limit;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign csr_hit = req & (wbs_adr_i[31:24] == USER_PAGE) & (wbs_adr_i[11:8] == CSR_PAGE);

    // The decoder must not see CSR accesses nor the terminating cycle of a
    // transaction this block is acking itself; reset blocks it immediately.
    assign fwd_block = wb_rst_i | csr_hit | (state == ST_ERR_ACK) | (state == ST_CSR_ACK);

    assign dec_cyc_o = wbs_cyc_i & ~fwd_block;
    assign dec_stb_o = wbs_stb_i & ~fwd_block;
    assign dec_we_o  = wbs_we_i;
    assign dec_sel_o = wbs_sel_i;
    assign dec_dat_o = wbs_dat_i;
    assign dec_adr_o = wbs_adr_i;

    assign wbs_ack_o = ack & ~wb_rst_i;
    assign wbs_dat_o = wb_rst_i ? 32'd0 : dat;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack       = 1'b0;
        dat       = '0;
        err_event = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (csr_hit) begin
                    state_nxt = ST_CSR_ACK;
                end else if (req) begin
                    // Zero-wait slaves complete without leaving IDLE.
                    ack = dec_ack_i;
                    dat = dec_ack_i ? dec_dat_i : 32'd0;
                    if (!dec_ack_i) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 16'd1;
                    end
                end
            end
            ST_WAIT: begin
                ack = dec_ack_i;
                dat = dec_dat_i;
                if (dec_ack_i || !req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= (limit - 16'd1)) begin
                    state_nxt = ST_ERR_ACK;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_ERR_ACK: begin
                ack       = 1'b1;
                dat       = ERR_DATA;
                err_event = 1'b1;
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            ST_CSR_ACK: begin
                ack       = 1'b1;
                dat       = csr_rdata;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // CSR writes commit and read data is captured on the request cycle, so a
    // LIMIT change can only land between transactions.
    wb_watchdog_csr #(
        .TIMEOUT_DEF (TIMEOUT_DEF)
    ) u_csr (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .wr_en     ((state == ST_IDLE) & csr_hit & wbs_we_i),
        .rd_en     ((state == ST_IDLE) & csr_hit),
        .offset    (wbs_adr_i[7:0]),
        .sel       (wbs_sel_i[1:0]),
        .wdata     (wbs_dat_i[15:0]),
        .busy      (state != ST_IDLE),
        .err_event (err_event),
        .err_adr   (wbs_adr_i),
        .rdata     (csr_rdata),
        .limit     (limit),
        .to_flag   (timeout_irq_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_watchdog
// Description : Self-checking bench for wb_bus_watchdog: directed scenarios
//               followed by random CSR and forwarded traffic, compared against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_watchdog;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] dat_w, adr;
    logic        dec_ack;
    logic [31:0] dec_dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dec_cyc_o, dec_stb_o, dec_we_o;
    logic [3:0]  dec_sel_o;
    logic [31:0] dec_dat_o, dec_adr_o;
    logic        timeout_irq_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_to;
    logic [15:0] m_cnt;
    logic [31:0] m_last;
    logic [15:0] m_limit;

    wb_bus_watchdog dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat_w),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .dec_cyc_o     (dec_cyc_o),
        .dec_stb_o     (dec_stb_o),
        .dec_we_o      (dec_we_o),
        .dec_sel_o     (dec_sel_o),
        .dec_dat_o     (dec_dat_o),
        .dec_adr_o     (dec_adr_o),
        .dec_ack_i     (dec_ack),
        .dec_dat_i     (dec_dat),
        .timeout_irq_o (timeout_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_to = 1'b0; m_cnt = '0; m_last = '0; m_limit = 16'd255;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00:   return {31'd0, m_to};
            8'h04:   return {16'd0, m_cnt};
            8'h08:   return m_last;
            8'h0C:   return {16'd0, m_limit};
            default: return 32'd0;
        endcase
    endfunction

    // One master transaction. The decoder acks d cycles after the request
    // cycle (d = 0: same cycle, d < 0: never). lat counts cycles from request.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] wd, input int d, input logic [31:0] rd,
                          output int lat, output logic [31:0] data,
                          output logic stb_first, output logic stb_at_ack,
                          output logic [31:0] adr_first);
        int k;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_w = wd; adr = a;
        k = 0; lat = -1; data = '0; stb_first = 1'b0; stb_at_ack = 1'b0; adr_first = '0;
        forever begin
            dec_ack = (k == d);
            dec_dat = (k == d) ? rd : $urandom;
            @(negedge clk);
            if (k == 0) begin
                stb_first = dec_stb_o;
                adr_first = dec_adr_o;
            end
            if (wbs_ack_o) begin
                lat = k; data = wbs_dat_o; stb_at_ack = dec_stb_o;
                break;
            end
            if (k >= 300) break;
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; dec_ack = 1'b0;
        @(negedge clk);
        check("no_extra_ack", {31'd0, wbs_ack_o}, 32'd0);
    endtask

    task automatic fwd(input logic [31:0] a, input logic w, input int d);
        int lat, exp_lat;
        logic [31:0] data, rd, exp_data, adr_first;
        logic sf, sa, exp_sa;
        rd = $urandom;
        access(a, w, 4'hF, $urandom, d, rd, lat, data, sf, sa, adr_first);
        if (d >= 0 && d < int'(m_limit)) begin
            exp_lat = d; exp_data = rd; exp_sa = 1'b1;
        end else begin
            exp_lat = int'(m_limit); exp_data = ERR; exp_sa = 1'b0;
            m_to = 1'b1; m_last = a;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        check("fwd_latency", lat, exp_lat);
        check("fwd_data", data, exp_data);
        check("fwd_stb_first", {31'd0, sf}, 32'd1);
        check("fwd_adr", adr_first, a);
        check("stb_at_ack", {31'd0, sa}, {31'd0, exp_sa});
        check("irq", {31'd0, timeout_irq_o}, {31'd0, m_to});
    endtask

    task automatic csr(input logic [7:0] off, input logic w, input logic [3:0] s,
                       input logic [31:0] wd);
        int lat;
        logic [31:0] data, a, exp_rd, adr_first, merged;
        logic sf, sa;
        a = {8'h30, 12'($urandom), 4'hF, off};
        exp_rd = model_read(off);
        access(a, w, s, wd, -1, 32'd0, lat, data, sf, sa, adr_first);
        check("csr_latency", lat, 1);
        check("csr_stb_blocked", {31'd0, sf}, 32'd0);
        check("csr_stb_at_ack", {31'd0, sa}, 32'd0);
        if (!w) check($sformatf("csr_read_%h", off), data, exp_rd);
        if (w) begin
            case (off)
                8'h00: if (s[0] && wd[0]) m_to = 1'b0;
                8'h04: m_cnt = '0;
                8'h0C: begin
                    merged = {16'd0, s[1] ? wd[15:8] : m_limit[15:8], s[0] ? wd[7:0] : m_limit[7:0]};
                    m_limit = (merged[15:0] < 16'd2) ? 16'd2 : merged[15:0];
                end
                default: ;
            endcase
        end
        check("irq_after_csr", {31'd0, timeout_irq_o}, {31'd0, m_to});
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  off;
        logic [31:0] wd;
        int          d;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        dat_w = '0; adr = '0; dec_ack = 1'b0; dec_dat = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_dec_cyc", {31'd0, dec_cyc_o}, 32'd0);
        check("rst_irq", {31'd0, timeout_irq_o}, 32'd0);
        rst = 1'b0;

        // Forwarded read, decoder acks 3 cycles later.
        fwd(32'h3000_0000, 1'b0, 3);
        csr(8'h00, 1'b0, 4'hF, 0);
        csr(8'h0C, 1'b0, 4'hF, 0);
        // Unmapped address with the default limit.
        fwd(32'h3000_0500, 1'b0, -1);
        csr(8'h00, 1'b0, 4'hF, 0);
        csr(8'h04, 1'b0, 4'hF, 0);
        csr(8'h08, 1'b0, 4'hF, 0);
        // Limit programming and clamping.
        csr(8'h0C, 1'b1, 4'hF, 32'd5);
        fwd(32'h3000_0600, 1'b1, -1);
        csr(8'h0C, 1'b1, 4'hF, 32'd0);
        csr(8'h0C, 1'b0, 4'hF, 0);
        // Sticky flag clear semantics.
        csr(8'h00, 1'b1, 4'h0, 32'h1);
        csr(8'h00, 1'b0, 4'hF, 0);
        csr(8'h00, 1'b1, 4'h1, 32'h1);
        csr(8'h00, 1'b0, 4'hF, 0);
        csr(8'h04, 1'b1, 4'h0, 32'h0);
        csr(8'h04, 1'b0, 4'hF, 0);
        // Ack at the last WAIT cycle versus ack during the error termination.
        csr(8'h0C, 1'b1, 4'h3, 32'd6);
        fwd(32'h3000_0700, 1'b0, 5);
        fwd(32'h3000_0704, 1'b0, 6);
        fwd(32'h3000_0708, 1'b0, 0);
        // Unknown CSR offset reads zero.
        csr(8'h10, 1'b1, 4'hF, 32'hFFFF_FFFF);
        csr(8'h10, 1'b0, 4'hF, 0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 4))
                    0: off = 8'h00;
                    1: off = 8'h04;
                    2: off = 8'h08;
                    3: off = 8'h0C;
                    default: off = 8'($urandom);
                endcase
                wd = (off == 8'h0C) ? 32'($urandom_range(0, 20)) : $urandom;
                csr(off, 1'($urandom), 4'($urandom), wd);
            end else begin
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a[31:24] = 8'h30;
                if (a[31:24] == 8'h30 && a[11:8] == 4'hF) a[8] = 1'b0;
                d = $urandom_range(0, int'(m_limit) + 2);
                if (d == int'(m_limit) + 2) d = -1;
                fwd(a, 1'($urandom), d);
            end
        end

        // Asynchronous reset in the middle of a waiting transaction.
        fwd(32'h3000_0800, 1'b0, -1);
        csr(8'h0C, 1'b1, 4'h3, 32'd200);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0900; dec_ack = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_stb", {31'd0, dec_stb_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_stb", {31'd0, dec_stb_o}, 32'd0);
        check("async_rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("async_rst_irq", {31'd0, timeout_irq_o}, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        csr(8'h0C, 1'b0, 4'hF, 0);
        csr(8'h00, 1'b0, 4'hF, 0);
        csr(8'h04, 1'b0, 4'hF, 0);
        csr(8'h08, 1'b0, 4'hF, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
